// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//
// Walks a per-level note ROM one entry per beat. It absorbs the ROM's
// one-cycle registered read latency and hands each non-rest note to the
// arrow-spawn logic. The level ends when the terminator code is read.
//
// Optional feature macro: SEQ_LOOP_EN
//   defined   : reading END_CODE restarts at address 0 (practice loop);
//               done never asserts through the terminator path.
//   undefined : reading END_CODE ends the level in DONE.
//
// Handshake: note_out/note_valid form a valid/ready source. A transfer
// occurs on a posedge where note_valid and note_ready are both high.
// note_valid is held, with note_out stable, until that transfer, and it
// drops in the following cycle.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst_n      in   synchronous active-low reset
//   start      in   begin the level (sampled only in IDLE or DONE)
//   pause      in   level-sensitive beat-timer freeze
//   rom_addr   out  address to the level ROM
//   rom_note   in   ROM data, valid one cycle after rom_addr
//   note_out   out  captured note (bit3 left, bit2 down, bit1 up, bit0 right)
//   note_valid out  note_out valid, held until note_ready
//   note_ready in   downstream accepts the note
//   beat_tick  out  one-cycle pulse per beat
//   busy       out  high from FETCH through PRESENT/WAIT_BEAT
//   done       out  high in DONE
//   overrun    out  sticky: a beat was lost while a note was stalled
//   dbg_state  out  current FSM state encoding, for observation
// -----------------------------------------------------------------------------
module note_sequencer #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 4,
    parameter int                    BEAT_DIV   = 12500000,
    parameter logic [DATA_WIDTH-1:0] END_CODE   = 4'b1111,
    parameter logic [DATA_WIDTH-1:0] REST_CODE  = 4'b0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  pause,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_note,
    output logic [DATA_WIDTH-1:0] note_out,
    output logic                  note_valid,
    input  logic                  note_ready,
    output logic                  beat_tick,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_CAPTURE   = 3'd2,
        S_PRESENT   = 3'd3,
        S_WAIT_BEAT = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [23:0] LP_DIV_M1 = 24'(BEAT_DIV - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [23:0]           r_cnt;
    logic                  r_pending;
    logic [DATA_WIDTH-1:0] r_note;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_overrun;

    logic w_running;
    logic w_tick;
    logic w_last;

    assign w_running = (r_state != S_IDLE) && (r_state != S_DONE);
    // The tick is qualified by pause so a frozen counter sitting on
    // BEAT_DIV-1 cannot fire repeatedly.
    assign w_tick    = w_running && !pause && (r_cnt == LP_DIV_M1);
    assign w_last    = (r_addr == {ADDR_WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_note    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_running && !pause) begin
                r_cnt <= w_tick ? 24'd0 : r_cnt + 24'd1;
            end

            // Only one beat can be remembered; a second one while the
            // first is still owed is lost and flagged.
            if (w_tick && r_pending) begin
                r_overrun <= 1'b1;
            end
            if (w_tick && (r_state != S_WAIT_BEAT)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_addr    <= '0;
                        r_cnt     <= '0;
                        r_overrun <= 1'b0;
                        r_pending <= 1'b0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // ROM registers rom_addr on this edge.
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (rom_note == END_CODE) begin
`ifdef SEQ_LOOP_EN
                        r_addr  <= '0;
                        r_state <= S_FETCH;
`else
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
`endif
                    end else if (rom_note == REST_CODE) begin
                        r_state <= S_WAIT_BEAT;
                    end else begin
                        r_note  <= rom_note;
                        r_valid <= 1'b1;
                        r_state <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (note_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_WAIT_BEAT;
                    end
                end
                S_WAIT_BEAT: begin
                    if (w_tick || r_pending) begin
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_addr    <= r_addr + 1'b1;
                            r_pending <= 1'b0;
                            r_state   <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr   = r_addr;
    assign note_out   = r_note;
    assign note_valid = r_valid;
    assign beat_tick  = w_tick;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overrun    = r_overrun;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
//
// Bench for note_sequencer with BEAT_DIV=8 and a one-cycle registered ROM.
// Cycle k is the interval that ends at posedge k, where posedge 0 is the
// edge that samples start. Expected notes are queued as {cycle, note} and
// popped by a monitor at every accepted handshake.
// -----------------------------------------------------------------------------
module tb_note_sequencer;

    localparam int AW = 6;
    localparam int DW = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          start      = 1'b0;
    logic          pause      = 1'b0;
    logic          note_ready = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_note;
    logic [DW-1:0] note_out;
    logic          note_valid;
    logic          beat_tick;
    logic          busy;
    logic          done;
    logic          overrun;
    logic [2:0]    dbg_state;

    logic [DW-1:0] rom [0:63];

    int tests    = 0;
    int fails    = 0;
    int edge_cnt = 0;
    int base     = 0;

    logic [15:0] exp_q[$];

    note_sequencer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BEAT_DIV   (8),
        .END_CODE   (4'b1111),
        .REST_CODE  (4'b0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .rom_addr   (rom_addr),
        .rom_note   (rom_note),
        .note_out   (note_out),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .beat_tick  (beat_tick),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / ROM model ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_note <= rom[rom_addr];
        edge_cnt <= edge_cnt + 1;
    end

    function automatic int rel();
        return edge_cnt - base;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [15:0] got;
        logic [15:0] exp;
        #2;
        if (rst_n && note_valid && note_ready) begin
            got   = {12'(rel()), note_out};
            tests = tests + 1;
            if (exp_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL handshake: got note %b at cycle %0d, required no note",
                         note_out, rel());
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    fails = fails + 1;
                    $display("FAIL handshake: got note %b at cycle %0d, required note %b at cycle %0d",
                             got[3:0], got[15:4], exp[3:0], exp[15:4]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, rel());
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic go_to(input int k);
        while (rel() < k) next_cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        next_cyc();
        next_cyc();
        rst_n = 1'b1;
        next_cyc();
    endtask

    task automatic start_level();
        start = 1'b1;
        next_cyc();
        start = 1'b0;
        base  = edge_cnt - 1;
    endtask

    task automatic fill(input logic [3:0] v0, input logic [3:0] v1,
                        input logic [3:0] v2, input logic [3:0] v3);
        for (int i = 0; i < 64; i++) rom[i] = 4'b1111;
        rom[0] = v0;
        rom[1] = v1;
        rom[2] = v2;
        rom[3] = v3;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(note_valid), 0);
        chk({tag, "_note"},  32'(note_out),   0);
        chk({tag, "_addr"},  32'(rom_addr),   0);
        chk({tag, "_tick"},  32'(beat_tick),  0);
        chk({tag, "_busy"},  32'(busy),       0);
        chk({tag, "_done"},  32'(done),       0);
        chk({tag, "_ovr"},   32'(overrun),    0);
        chk({tag, "_state"}, 32'(dbg_state),  32'(ST_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        fill(4'b1000, 4'b0010, 4'b1111, 4'b1111);

        // Reset with arbitrary inputs.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start      = 1'($urandom_range(0, 1));
            pause      = 1'($urandom_range(0, 1));
            note_ready = 1'($urandom_range(0, 1));
            next_cyc();
        end
        chk_all_zero("reset");
        note_ready = 1'b0;
        do_reset();

`ifndef SEQ_LOOP_EN
        // Basic sequence, plus a start pulse while busy that must be ignored.
        note_ready = 1'b1;
        exp_q.push_back({12'd3, 4'b1000});
        exp_q.push_back({12'd11, 4'b0010});
        start_level();
        chk("basic_busy1", 32'(busy), 1);
        chk("basic_addr1", 32'(rom_addr), 0);
        chk("basic_fetch1", 32'(dbg_state), 32'(ST_FETCH));
        go_to(2);
        chk("basic_capture2", 32'(dbg_state), 32'(ST_CAPTURE));
        go_to(4);
        chk("basic_valid_drop4", 32'(note_valid), 0);
        go_to(5);
        start = 1'b1;
        go_to(6);
        start = 1'b0;
        go_to(7);
        chk("basic_tick7", 32'(beat_tick), 0);
        go_to(8);
        chk("basic_tick8", 32'(beat_tick), 1);
        go_to(9);
        chk("basic_addr9", 32'(rom_addr), 1);
        go_to(17);
        chk("basic_addr17", 32'(rom_addr), 2);
        go_to(18);
        chk("basic_done18", 32'(done), 0);
        go_to(19);
        chk("basic_done19", 32'(done), 1);
        chk("basic_busy19", 32'(busy), 0);
        chk("basic_state19", 32'(dbg_state), 32'(ST_DONE));
        next_cyc();

        // Restart from DONE.
        exp_q.push_back({12'd3, 4'b1000});
        exp_q.push_back({12'd11, 4'b0010});
        start_level();
        chk("restart_busy1", 32'(busy), 1);
        chk("restart_done1", 32'(done), 0);
        go_to(19);
        chk("restart_done19", 32'(done), 1);
        chk("basic_queue", 32'(exp_q.size()), 0);
        do_reset();

        // Rest beat.
        fill(4'b0100, 4'b0000, 4'b0001, 4'b1111);
        note_ready = 1'b1;
        exp_q.push_back({12'd3, 4'b0100});
        exp_q.push_back({12'd19, 4'b0001});
        start_level();
        go_to(11);
        chk("rest_valid11", 32'(note_valid), 0);
        chk("rest_state11", 32'(dbg_state), 32'(ST_WAIT));
        go_to(26);
        chk("rest_done26", 32'(done), 0);
        go_to(27);
        chk("rest_done27", 32'(done), 1);
        chk("rest_queue", 32'(exp_q.size()), 0);
        do_reset();

        // Stall and overrun.
        fill(4'b1000, 4'b0010, 4'b1111, 4'b1111);
        note_ready = 1'b0;
        exp_q.push_back({12'd21, 4'b1000});
        exp_q.push_back({12'd25, 4'b0010});
        start_level();
        for (int k = 3; k <= 20; k++) begin
            go_to(k);
            chk("stall_valid", 32'(note_valid), 1);
            chk("stall_note", 32'(note_out), 32'(4'b1000));
            if (k == 16) chk("stall_ovr16", 32'(overrun), 0);
            if (k == 17) chk("stall_ovr17", 32'(overrun), 1);
        end
        go_to(21);
        note_ready = 1'b1;
        go_to(22);
        chk("stall_valid22", 32'(note_valid), 0);
        chk("stall_addr22", 32'(rom_addr), 0);
        go_to(23);
        chk("stall_fetch23", 32'(dbg_state), 32'(ST_FETCH));
        chk("stall_addr23", 32'(rom_addr), 1);
        go_to(29);
        chk("stall_done29", 32'(done), 1);
        chk("stall_ovr_sticky", 32'(overrun), 1);
        chk("stall_queue", 32'(exp_q.size()), 0);
        do_reset();

        // Pause freezes beat timing.
        note_ready = 1'b1;
        exp_q.push_back({12'd3, 4'b1000});
        exp_q.push_back({12'd21, 4'b0010});
        start_level();
        go_to(5);
        pause = 1'b1;
        for (int k = 5; k <= 14; k++) begin
            go_to(k);
            chk("pause_tick", 32'(beat_tick), 0);
        end
        go_to(15);
        pause = 1'b0;
        go_to(17);
        chk("pause_tick17", 32'(beat_tick), 0);
        go_to(18);
        chk("pause_tick18", 32'(beat_tick), 1);
        go_to(19);
        chk("pause_fetch19", 32'(dbg_state), 32'(ST_FETCH));
        chk("pause_addr19", 32'(rom_addr), 1);
        go_to(29);
        chk("pause_done29", 32'(done), 1);
        chk("pause_queue", 32'(exp_q.size()), 0);
        do_reset();

        // Reset mid-handshake, then a fresh start.
        note_ready = 1'b0;
        start_level();
        go_to(12);
        chk("midrst_valid12", 32'(note_valid), 1);
        rst_n = 1'b0;
        go_to(13);
        chk_all_zero("midrst");
        rst_n      = 1'b1;
        note_ready = 1'b1;
        next_cyc();
        exp_q.push_back({12'd3, 4'b1000});
        exp_q.push_back({12'd11, 4'b0010});
        start_level();
        go_to(19);
        chk("midrst_done19", 32'(done), 1);
        chk("midrst_queue", 32'(exp_q.size()), 0);
        do_reset();
`else
        // Practice loop: the terminator restarts at address 0.
        fill(4'b1000, 4'b1111, 4'b1111, 4'b1111);
        note_ready = 1'b1;
        exp_q.push_back({12'd3, 4'b1000});
        exp_q.push_back({12'd13, 4'b1000});
        exp_q.push_back({12'd21, 4'b1000});
        exp_q.push_back({12'd29, 4'b1000});
        start_level();
        go_to(10);
        chk("loop_capture10", 32'(dbg_state), 32'(ST_CAPTURE));
        chk("loop_addr10", 32'(rom_addr), 1);
        go_to(11);
        chk("loop_fetch11", 32'(dbg_state), 32'(ST_FETCH));
        chk("loop_addr11", 32'(rom_addr), 0);
        for (int k = 11; k <= 30; k++) begin
            go_to(k);
            chk("loop_done", 32'(done), 0);
        end
        chk("loop_queue", 32'(exp_q.size()), 0);
        do_reset();
`endif

        chk("final_queue", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
